// File: rtl/layer_out_stage.sv
// -----------------------------------------------------------------------------
// layer_out_stage
//
// Output stage of a convolution layer. Each accepted pixel carries one signed
// accumulator per channel. Each one is quantised in three steps: a rounding
// arithmetic right shift, then ReLU, then saturation to DATA_WIDTH. The packed
// channel words are written to the layer output memory in raster order. A
// one-cycle done pulse follows the last write of the frame.
//
// Optional feature (macro MAXPOOL_2X2_EN): when defined, a 2x2 stride-2
// max-pool sits between quantisation and the memory write. It uses a line
// buffer of FMAP_W/2 packed words and a horizontal partial register. When
// undefined, no pool logic is built and every pixel produces one write.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   start        one-cycle frame-start pulse (accepted in IDLE only)
//   shift        quantisation right-shift, latched on accepted start
//   result_valid result_all holds one pixel (accepted in RUN only)
//   result_all   packed signed accumulators, ch0 at LSBs
//   busy         frame in progress (RUN/DRAIN/DONE)
//   done         one-cycle pulse, cycle after the final write
//   wr_en        output memory write strobe
//   wr_addr      output memory address
//   wr_data_all  packed quantised words, ch0 at LSBs
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshake: there is no back-pressure. Every cycle with result_valid=1 while
// in RUN consumes exactly one pixel. The write for it appears on wr_en exactly
// 2 cycles later.
// -----------------------------------------------------------------------------
module layer_out_stage #(
  parameter int NUM_CH           = 4,
  parameter int ACCUM_DATA_WIDTH = 32,
  parameter int DATA_WIDTH       = 8,
  parameter int FMAP_W           = 8,
  parameter int FMAP_H           = 8,
  parameter int OUT_ADDR_WIDTH   = 10,
  parameter int SHIFT_WIDTH      = 5
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [SHIFT_WIDTH-1:0]             shift,
  input  logic                               result_valid,
  input  logic [ACCUM_DATA_WIDTH*NUM_CH-1:0] result_all,
  output logic                               busy,
  output logic                               done,
  output logic                               wr_en,
  output logic [OUT_ADDR_WIDTH-1:0]          wr_addr,
  output logic [DATA_WIDTH*NUM_CH-1:0]       wr_data_all,
  output logic [1:0]                         dbg_state
);

  localparam int A     = ACCUM_DATA_WIDTH;
  localparam int D     = DATA_WIDTH;
  localparam int ROW_W = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
  localparam int COL_W = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;

  // Largest positive output value, at output width and at extended width.
  localparam logic signed [A:0] SAT_EXT = {{(A+2-D){1'b0}}, {(D-1){1'b1}}};
  localparam logic [D-1:0]      SAT_D   = {1'b0, {(D-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [SHIFT_WIDTH-1:0]  r_shift;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic                    r_s1_valid;
  logic [D*NUM_CH-1:0]     r_s1_data;
  logic                    w_accept;
  logic                    w_last_col;
  logic                    w_last_row;
  logic [D*NUM_CH-1:0]     w_q_all;

  assign w_accept   = (r_state == S_RUN) && result_valid;
  assign w_last_col = (r_col == COL_W'(FMAP_W - 1));
  assign w_last_row = (r_row == ROW_W'(FMAP_H - 1));
  assign dbg_state  = r_state;

  // The sum is formed at A+1 bits, so adding the rounding constant cannot
  // wrap. One example is a maximum positive accumulator.
  function automatic logic [D-1:0] quantise(input logic [A-1:0] acc,
                                            input logic [SHIFT_WIDTH-1:0] s);
    logic signed [A:0] ext;
    logic signed [A:0] rnd;
    logic signed [A:0] v;
    logic        [A:0] one;
    one = {{A{1'b0}}, 1'b1};
    ext = $signed({acc[A-1], acc});
    rnd = '0;
    if (s != '0) rnd = $signed(one << (s - 1'b1));
    v = (ext + rnd) >>> s;
    if (v < 0)            return '0;
    else if (v > SAT_EXT) return SAT_D;
    else                  return v[D-1:0];
  endfunction

  always_comb begin
    w_q_all = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_q_all[c*D +: D] = quantise(result_all[c*A +: A], r_shift);
    end
  end

  // Control FSM, raster counters and registered busy/done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_row   <= '0;
      r_col   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_shift <= shift;
            r_row   <= '0;
            r_col   <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
              if (w_last_row) r_state <= S_DRAIN;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Once stage 1 is empty, the final write is either on wr_en in
          // this cycle or has already issued. Done then lands one cycle
          // after that write.
          if (!r_s1_valid) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef MAXPOOL_2X2_EN
  // Plain raster path: the address counts accepted pixels within the frame.
  logic [OUT_ADDR_WIDTH-1:0] r_pix_addr;
  logic [OUT_ADDR_WIDTH-1:0] r_s1_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pix_addr <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (r_state == S_IDLE && start) r_pix_addr <= '0;
      else if (w_accept)              r_pix_addr <= r_pix_addr + 1'b1;
      if (w_accept) begin
        r_s1_data <= w_q_all;
        r_s1_addr <= r_pix_addr;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data_all <= '0;
    end else begin
      wr_en <= r_s1_valid;
      if (r_s1_valid) begin
        wr_addr     <= r_s1_addr;
        wr_data_all <= r_s1_data;
      end
    end
  end
`else
  localparam int HALF   = (FMAP_W / 2 > 0) ? FMAP_W / 2 : 1;
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic                      r_s1_row_odd;
  logic                      r_s1_col_odd;
  logic [HALF_W-1:0]         r_s1_col_half;
  logic [D*NUM_CH-1:0]       r_hpart;
  logic [D*NUM_CH-1:0]       r_lbuf [HALF];
  logic [OUT_ADDR_WIDTH-1:0] r_pool_addr;
  logic [D*NUM_CH-1:0]       w_pair;
  logic [D*NUM_CH-1:0]       w_pool;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_row_odd  <= 1'b0;
      r_s1_col_odd  <= 1'b0;
      r_s1_col_half <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data     <= w_q_all;
        r_s1_row_odd  <= r_row[0];
        r_s1_col_odd  <= r_col[0];
        r_s1_col_half <= HALF_W'(r_col >> 1);
      end
    end
  end

  // Quantised words are never negative, so an unsigned compare gives the max.
  always_comb begin
    w_pair = '0;
    w_pool = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pair[c*D +: D] = (r_hpart[c*D +: D] > r_s1_data[c*D +: D]) ?
                         r_hpart[c*D +: D] : r_s1_data[c*D +: D];
      w_pool[c*D +: D] = (r_lbuf[r_s1_col_half][c*D +: D] > w_pair[c*D +: D]) ?
                         r_lbuf[r_s1_col_half][c*D +: D] : w_pair[c*D +: D];
    end
  end

  // Even column: hold the value. Odd column on an even row: park the pair max
  // in the line buffer. Odd column on an odd row: emit the 2x2 max.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data_all <= '0;
      r_hpart     <= '0;
      r_pool_addr <= '0;
      for (int i = 0; i < HALF; i++) r_lbuf[i] <= '0;
    end else begin
      wr_en <= r_s1_valid && r_s1_row_odd && r_s1_col_odd;
      if (r_state == S_IDLE && start) r_pool_addr <= '0;
      if (r_s1_valid) begin
        if (!r_s1_col_odd) begin
          r_hpart <= r_s1_data;
        end else if (!r_s1_row_odd) begin
          r_lbuf[r_s1_col_half] <= w_pair;
        end else begin
          wr_addr     <= r_pool_addr;
          wr_data_all <= w_pool;
          r_pool_addr <= r_pool_addr + 1'b1;
        end
      end
    end
  end
`endif

endmodule
